// File: rtl/md5_cmd_pkg.sv
// md5_cmd_pkg: shared command codes, FSM state type and word-packing helper for the MD5 command sequencer.
//   Contents: CMD_* 32-bit command words, word-ROM index bounds, seq_state_t, pack_range().
//   Optional feature macro used by the sequencer: MD5_SEQ_TIMEOUT_EN.
package md5_cmd_pkg;

  localparam logic [31:0] CMD_NOOP      = 32'h0000_0000;
  localparam logic [31:0] CMD_RESET_GEN = 32'h5230_0000;
  localparam logic [31:0] CMD_START_GEN = 32'h5230_0001;
  localparam logic [31:0] CMD_SET_A     = 32'h5230_1000;
  localparam logic [31:0] CMD_SET_B     = 32'h5230_1001;
  localparam logic [31:0] CMD_SET_C     = 32'h5230_1002;
  localparam logic [31:0] CMD_SET_D     = 32'h5230_1003;
  localparam logic [31:0] CMD_SET_RANGE = 32'h5230_2000;
  localparam logic [31:0] CMD_COUNT_LO  = 32'h5230_3000;
  localparam logic [31:0] CMD_COUNT_HI  = 32'h5230_3001;
  localparam logic [31:0] CMD_TEXT1     = 32'h4400_0001;
  localparam logic [31:0] CMD_TEXT2     = 32'h4400_0002;
  localparam logic [31:0] CMD_TEXT3     = 32'h4400_0003;
  localparam logic [31:0] CMD_TEXT4     = 32'h4400_0004;

  // Word ROM layout: 0..11 program words, 12..17 readback words.
  localparam logic [4:0] IDX_LAST_PROG = 5'd11;
  localparam logic [4:0] IDX_FIRST_RB  = 5'd12;
  localparam logic [4:0] IDX_LAST_RB   = 5'd17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROGRAM,
    ST_POLL,
    ST_READBACK,
    ST_TIMEOUT
  } seq_state_t;

  function automatic logic [31:0] pack_range(input logic [7:0] rmax, input logic [7:0] rmin);
    return {16'h0000, rmax, rmin};
  endfunction

endpackage

// File: rtl/md5_cmd_strobe_gen.sv
// md5_cmd_strobe_gen: issues one command word slot (data held, strobe high then low) per load pulse.
//   Ports: clk, reset (async, active-high); load/word start a slot; clear drops strobe and zeroes cmd_data;
//   cmd_data/cmd_strobe drive the cracker; sample marks the last low cycle; slot_done pulses with it.
//   Parameters: STROBE_HIGH (>=1) strobe-high cycles, STROBE_LOW (>=3) strobe-low cycles.
module md5_cmd_strobe_gen #(
  parameter int STROBE_HIGH = 4,
  parameter int STROBE_LOW  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] word,
  output logic [31:0] cmd_data,
  output logic        cmd_strobe,
  output logic        sample,
  output logic        slot_done
);

  localparam logic [15:0] HI   = 16'(STROBE_HIGH);
  localparam logic [15:0] LAST = 16'(STROBE_HIGH + STROBE_LOW - 1);

  logic        active;
  logic [15:0] cnt;

  // cnt counts cycles of the current slot; a load in the last cycle chains the next slot back-to-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_data   <= '0;
      cmd_strobe <= 1'b0;
      active     <= 1'b0;
      cnt        <= '0;
    end else if (clear) begin
      cmd_data   <= '0;
      cmd_strobe <= 1'b0;
      active     <= 1'b0;
      cnt        <= '0;
    end else if (load) begin
      cmd_data   <= word;
      cmd_strobe <= 1'b1;
      active     <= 1'b1;
      cnt        <= '0;
    end else if (active) begin
      cnt        <= cnt + 16'd1;
      cmd_strobe <= (cnt + 16'd1) < HI;
      active     <= cnt != LAST;
    end
  end

  assign sample    = active && cnt == LAST;
  assign slot_done = sample;

endmodule

// File: rtl/md5_cmd_sequencer.sv
// md5_cmd_sequencer: host-side initiator that programs the MD5 cracker, waits for a match and reads back text/count.
//   Ports: clk, reset (async, active-high); start/abort pulses; target[127:0] {A,B,C,D}; range_min/range_max;
//   matched_in (async cracker hasMatched); resp_in (cracker dataOut); cmd_data/cmd_strobe (cracker dataIn/hasReceived);
//   busy, done (1-cycle), timed_out (sticky), text {w4,w3,w2,w1}, count {high,low}.
//   Optional feature: define MD5_SEQ_TIMEOUT_EN to abort POLL after TIMEOUT cycles with a generator reset word.
module md5_cmd_sequencer
  import md5_cmd_pkg::*;
#(
  parameter int          STROBE_HIGH = 4,
  parameter int          STROBE_LOW  = 4,
  parameter logic [31:0] TIMEOUT     = 32'hffff_ffff
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] target,
  input  logic [7:0]   range_min,
  input  logic [7:0]   range_max,
  input  logic         matched_in,
  input  logic [31:0]  resp_in,
  output logic [31:0]  cmd_data,
  output logic         cmd_strobe,
  output logic         busy,
  output logic         done,
  output logic         timed_out,
  output logic [127:0] text,
  output logic [63:0]  count
);

  seq_state_t   state, state_n;
  logic [4:0]   idx, idx_n;
  logic [127:0] tgt;
  logic [7:0]   rmin, rmax;
  logic [1:0]   sync;
  logic         match_s, accept, load, sample, slot_done, tmo_hit;
  logic [31:0]  rom_word;

  assign match_s = sync[1];
  assign accept  = state == ST_IDLE && start && !abort;
  assign busy    = state != ST_IDLE;

  md5_cmd_strobe_gen #(
    .STROBE_HIGH(STROBE_HIGH),
    .STROBE_LOW (STROBE_LOW)
  ) u_strobe (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .clear     (abort),
    .word      (rom_word),
    .cmd_data  (cmd_data),
    .cmd_strobe(cmd_strobe),
    .sample    (sample),
    .slot_done (slot_done)
  );

  // Indexed by idx_n so the word for the slot being loaded is ready in the load cycle.
  always_comb begin
    rom_word = CMD_NOOP;
    case (idx_n)
      5'd0:  rom_word = CMD_RESET_GEN;
      5'd1:  rom_word = CMD_SET_A;
      5'd2:  rom_word = tgt[127:96];
      5'd3:  rom_word = CMD_SET_B;
      5'd4:  rom_word = tgt[95:64];
      5'd5:  rom_word = CMD_SET_C;
      5'd6:  rom_word = tgt[63:32];
      5'd7:  rom_word = CMD_SET_D;
      5'd8:  rom_word = tgt[31:0];
      5'd9:  rom_word = CMD_SET_RANGE;
      5'd10: rom_word = pack_range(rmax, rmin);
      5'd11: rom_word = CMD_START_GEN;
      5'd12: rom_word = CMD_TEXT1;
      5'd13: rom_word = CMD_TEXT2;
      5'd14: rom_word = CMD_TEXT3;
      5'd15: rom_word = CMD_TEXT4;
      5'd16: rom_word = CMD_COUNT_LO;
      5'd17: rom_word = CMD_COUNT_HI;
      default: rom_word = CMD_NOOP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    if (abort)
      state_n = ST_IDLE;
    else
      case (state)
        ST_IDLE:     state_n = start ? ST_PROGRAM : ST_IDLE;
        ST_PROGRAM:  state_n = (slot_done && idx == IDX_LAST_PROG) ? ST_POLL : ST_PROGRAM;
        ST_POLL:     state_n = match_s ? ST_READBACK : tmo_hit ? ST_TIMEOUT : ST_POLL;
        ST_READBACK: state_n = (slot_done && idx == IDX_LAST_RB) ? ST_IDLE : ST_READBACK;
        ST_TIMEOUT:  state_n = slot_done ? ST_IDLE : ST_TIMEOUT;
        default:     state_n = ST_IDLE;
      endcase
  end

  // A match in the same cycle as the timeout wins, so a late hit is never thrown away.
  always_comb begin
    load  = 1'b0;
    idx_n = idx;
    if (!abort)
      case (state)
        ST_IDLE: begin
          load  = start;
          idx_n = start ? 5'd0 : idx;
        end
        ST_PROGRAM, ST_READBACK: begin
          load  = slot_done && idx != IDX_LAST_PROG && idx != IDX_LAST_RB;
          idx_n = load ? idx + 5'd1 : idx;
        end
        ST_POLL: begin
          load  = match_s || tmo_hit;
          idx_n = match_s ? IDX_FIRST_RB : tmo_hit ? 5'd0 : idx;
        end
        default: ;
      endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt   <= '0;
      rmin  <= '0;
      rmax  <= '0;
      sync  <= '0;
      text  <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      sync <= {sync[0], matched_in};
      done <= !abort && state == ST_READBACK && slot_done && idx == IDX_LAST_RB;
      if (accept) begin
        tgt  <= target;
        rmin <= range_min;
        rmax <= range_max;
      end
      if (!abort && state == ST_READBACK && sample)
        case (idx)
          5'd12:   text[31:0]    <= resp_in;
          5'd13:   text[63:32]   <= resp_in;
          5'd14:   text[95:64]   <= resp_in;
          5'd15:   text[127:96]  <= resp_in;
          5'd16:   count[31:0]   <= resp_in;
          5'd17:   count[63:32]  <= resp_in;
          default: ;
        endcase
    end
  end

`ifdef MD5_SEQ_TIMEOUT_EN
  logic [31:0] poll_cnt;

  // poll_cnt equals the number of completed POLL cycles; it restarts whenever POLL is left.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt  <= '0;
      timed_out <= 1'b0;
    end else begin
      poll_cnt <= state == ST_POLL ? poll_cnt + 32'd1 : '0;
      if (accept)
        timed_out <= 1'b0;
      else if (!abort && tmo_hit && !match_s)
        timed_out <= 1'b1;
    end
  end

  assign tmo_hit = state == ST_POLL && poll_cnt == TIMEOUT - 32'd1;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
  assign timed_out      = 1'b0;
`endif

endmodule

// File: tb/tb_md5_cmd_sequencer.sv
// tb_md5_cmd_sequencer: directed, table-driven bench for md5_cmd_sequencer with a small cracker response model.
module tb_md5_cmd_sequencer;

`ifdef MD5_SEQ_TIMEOUT_EN
  localparam logic [31:0] TMO         = 32'd50;
  localparam int          MATCH_DELAY = 20;
`else
  localparam logic [31:0] TMO         = 32'hffff_ffff;
  localparam int          MATCH_DELAY = 100;
`endif

  logic         clk = 1'b0;
  logic         reset, start, abort, matched_in;
  logic [127:0] target;
  logic [7:0]   range_min, range_max;
  logic [31:0]  resp_in, cmd_data;
  logic         cmd_strobe, busy, done, timed_out;
  logic [127:0] text;
  logic [63:0]  count;

  always #5 clk = ~clk;

  md5_cmd_sequencer #(
    .STROBE_HIGH(4),
    .STROBE_LOW (4),
    .TIMEOUT    (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .target    (target),
    .range_min (range_min),
    .range_max (range_max),
    .matched_in(matched_in),
    .resp_in   (resp_in),
    .cmd_data  (cmd_data),
    .cmd_strobe(cmd_strobe),
    .busy      (busy),
    .done      (done),
    .timed_out (timed_out),
    .text      (text),
    .count     (count)
  );

  typedef struct {
    logic [127:0] tgt;
    logic [7:0]   rmin;
    logic [7:0]   rmax;
    logic [31:0]  rng_word;
    logic [31:0]  w1, w2, w3, w4, cl, ch;
    logic [127:0] exp_text;
    logic [63:0]  exp_count;
  } vec_t;

  vec_t        vecs [3];
  logic [31:0] rsp [6];

  // Cracker model: dataOut answers the command word currently presented.
  always_comb begin
    case (cmd_data)
      32'h4400_0001: resp_in = rsp[0];
      32'h4400_0002: resp_in = rsp[1];
      32'h4400_0003: resp_in = rsp[2];
      32'h4400_0004: resp_in = rsp[3];
      32'h5230_3000: resp_in = rsp[4];
      32'h5230_3001: resp_in = rsp[5];
      default:       resp_in = 32'h0;
    endcase
  end

  int          total = 0, bad = 0, cycles = 0;
  int          done_cnt, mon_bad, hi_len, lo_len;
  bit          prev_s, have_fall;
  logic [31:0] words [$];
  logic [31:0] last_w;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock, sampled at the falling edge; also tracks strobe shape and cmd_data stability.
  task automatic tick();
    @(negedge clk);
    cycles++;
    if (done) done_cnt++;
    if (cmd_strobe && !prev_s) begin
      if (have_fall && words.size() != 12 && lo_len != 4) mon_bad++;
      words.push_back(cmd_data);
      last_w = cmd_data;
      hi_len = 1;
    end else if (cmd_strobe) begin
      hi_len++;
      if (cmd_data !== last_w) mon_bad++;
    end else if (prev_s) begin
      if (hi_len != 4) mon_bad++;
      if (cmd_data !== last_w) mon_bad++;
      lo_len    = 1;
      have_fall = 1;
    end else begin
      lo_len++;
    end
    prev_s = cmd_strobe;
  endtask

  task automatic mon_reset();
    words.delete();
    have_fall = 0;
    mon_bad   = 0;
    done_cnt  = 0;
    hi_len    = 0;
    lo_len    = 0;
    prev_s    = cmd_strobe;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (words.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk($sformatf("reach_%0d_words", n), 128'(words.size() >= n), 128'd1);
  endtask

  task automatic start_job(input int i, input bit dbl);
    rsp[0]    = vecs[i].w1;
    rsp[1]    = vecs[i].w2;
    rsp[2]    = vecs[i].w3;
    rsp[3]    = vecs[i].w4;
    rsp[4]    = vecs[i].cl;
    rsp[5]    = vecs[i].ch;
    target    = vecs[i].tgt;
    range_min = vecs[i].rmin;
    range_max = vecs[i].rmax;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    target    = ~vecs[i].tgt;
    range_min = 8'h00;
    range_max = 8'h01;
    if (dbl) begin
      tick();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  task automatic finish_job(input int i);
    logic [31:0] e [18];
    int k = 0;
    e = '{32'h5230_0000, 32'h5230_1000, vecs[i].tgt[127:96], 32'h5230_1001, vecs[i].tgt[95:64],
          32'h5230_1002, vecs[i].tgt[63:32], 32'h5230_1003, vecs[i].tgt[31:0], 32'h5230_2000,
          vecs[i].rng_word, 32'h5230_0001, 32'h4400_0001, 32'h4400_0002, 32'h4400_0003,
          32'h4400_0004, 32'h5230_3000, 32'h5230_3001};
    wait_words(12, 400);
    repeat (8 + MATCH_DELAY) tick();
    chk("poll_no_strobes", 128'(words.size()), 128'd12);
    matched_in = 1'b1;
    while (done_cnt == 0 && k < 300) begin
      tick();
      k++;
    end
    chk("done_seen", 128'(done_cnt), 128'd1);
    chk("busy_at_done", 128'(busy), 128'd0);
    matched_in = 1'b0;
    repeat (3) tick();
    chk("done_one_cycle", 128'(done_cnt), 128'd1);
    chk("word_count", 128'(words.size()), 128'd18);
    for (int j = 0; j < 18; j++)
      chk($sformatf("word%0d", j), 128'(j < words.size() ? words[j] : 32'hxxxx_xxxx), 128'(e[j]));
    chk("strobe_shape", 128'(mon_bad), 128'd0);
    chk("text", text, vecs[i].exp_text);
    chk("count", 128'(count), 128'(vecs[i].exp_count));
    chk("timed_out_clear", 128'(timed_out), 128'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_data"}, 128'(cmd_data), 128'd0);
    chk({tag, "_cmd_strobe"}, 128'(cmd_strobe), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_done"}, 128'(done), 128'd0);
    chk({tag, "_timed_out"}, 128'(timed_out), 128'd0);
    chk({tag, "_text"}, text, 128'd0);
    chk({tag, "_count"}, 128'(count), 128'd0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    matched_in = 1'b0;
    target     = '0;
    range_min  = '0;
    range_max  = '0;
    for (int j = 0; j < 6; j++) rsp[j] = '0;
    vecs[0] = '{tgt: 128'h2971bc83_9b41f6a4_955620c0_9067fbfd, rmin: 8'h61, rmax: 8'h7a, rng_word: 32'h0000_7a61,
                w1: 32'h6463_6261, w2: 32'h0, w3: 32'h0, w4: 32'h0, cl: 32'h1234, ch: 32'h0,
                exp_text: 128'h00000000_00000000_00000000_64636261, exp_count: 64'h00000000_00001234};
    vecs[1] = '{tgt: 128'h01234567_89abcdef_fedcba98_76543210, rmin: 8'h30, rmax: 8'h39, rng_word: 32'h0000_3930,
                w1: 32'h1111_1111, w2: 32'h2222_2222, w3: 32'h3333_3333, w4: 32'h4444_4444,
                cl: 32'hdead_beef, ch: 32'h0000_0001,
                exp_text: 128'h44444444_33333333_22222222_11111111, exp_count: 64'h00000001_deadbeef};
    vecs[2] = '{tgt: 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a, rmin: 8'h00, rmax: 8'hff, rng_word: 32'h0000_ff00,
                w1: 32'hdead_beef, w2: 32'hcafe_f00d, w3: 32'h0123_4567, w4: 32'h89ab_cdef,
                cl: 32'h0000_0000, ch: 32'hffff_ffff,
                exp_text: 128'h89abcdef_01234567_cafef00d_deadbeef, exp_count: 64'hffffffff_00000000};

    #1;
    chk_reset_vals("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Full jobs from the table; job 1 also gets a second start pulse while busy.
    for (int i = 0; i < 3; i++) begin
      mon_reset();
      start_job(i, i == 1);
      finish_job(i);
    end

    // Abort in the middle of the 7th program word.
    mon_reset();
    start_job(0, 0);
    wait_words(7, 200);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_strobe_low", 128'(cmd_strobe), 128'd0);
    chk("abort_busy_low", 128'(busy), 128'd0);
    chk("abort_cmd_data", 128'(cmd_data), 128'd0);
    repeat (40) tick();
    chk("abort_no_done", 128'(done_cnt), 128'd0);
    chk("abort_no_more_words", 128'(words.size()), 128'd7);
    chk("abort_text_kept", text, vecs[2].exp_text);
    chk("abort_count_kept", 128'(count), 128'(vecs[2].exp_count));
    mon_reset();
    start_job(0, 0);
    finish_job(0);

    // start together with abort in IDLE: nothing starts.
    mon_reset();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    repeat (40) tick();
    chk("start_abort_no_words", 128'(words.size()), 128'd0);
    chk("start_abort_not_busy", 128'(busy), 128'd0);
    chk("start_abort_no_done", 128'(done_cnt), 128'd0);

`ifdef MD5_SEQ_TIMEOUT_EN
    begin
      int t0, k;
      mon_reset();
      start_job(1, 0);
      wait_words(12, 400);
      t0 = cycles;
      k  = 0;
      while (!timed_out && k < 300) begin
        tick();
        k++;
      end
      chk("tmo_latency", 128'(cycles - t0), 128'(8 + 50));
      chk("tmo_word_count", 128'(words.size()), 128'd13);
      chk("tmo_word", 128'(words.size() > 12 ? words[12] : 32'hxxxx_xxxx), 128'h5230_0000);
      repeat (20) tick();
      chk("tmo_not_busy", 128'(busy), 128'd0);
      chk("tmo_no_done", 128'(done_cnt), 128'd0);
      chk("tmo_sticky", 128'(timed_out), 128'd1);
      chk("tmo_text_kept", text, vecs[0].exp_text);
      chk("tmo_count_kept", 128'(count), 128'(vecs[0].exp_count));
    end
`else
    chk("timed_out_tied", 128'(timed_out), 128'd0);
`endif

    // Reset in the middle of readback, with matched_in already high before POLL.
    mon_reset();
    start_job(2, 0);
    wait_words(12, 400);
    matched_in = 1'b1;
    wait_words(14, 200);
    tick();
    matched_in = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_vals("mid_reset");
    tick();
    reset = 1'b0;
    tick();
    mon_reset();
    start_job(1, 0);
    finish_job(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
